// File: rtl/window_3x3_gen_if.sv
// Stream interface for the 3x3 window generator.
// The pixel source drives the raster side; the window side returns the neighbourhood.
interface window_3x3_gen_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  refresh;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_pixel;
    logic                  out_valid;
    logic                  out_eof;
    logic [DATA_WIDTH-1:0] w0, w1, w2, w3, w4, w5, w6, w7, w8;

    modport master (
        output refresh, in_valid, in_pixel,
        input  out_valid, out_eof, w0, w1, w2, w3, w4, w5, w6, w7, w8
    );

    modport slave (
        input  refresh, in_valid, in_pixel,
        output out_valid, out_eof, w0, w1, w2, w3, w4, w5, w6, w7, w8
    );
endinterface

// File: rtl/window_3x3_gen.sv
// Raster pixel stream to 3x3 neighbourhood window, using two row-deep line buffers.
// A window is flagged valid only when all nine pixels belong to the current frame.
module window_3x3_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                clk,
    input  logic                rst,
    window_3x3_gen_if.slave     bus
);
    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    logic [COL_W-1:0]      col_p0;
    logic [ROW_W-1:0]      row_p0;
    logic                  clr_p0;
    logic                  acc_p0;
    logic                  in_win_p0;
    logic                  last_p0;
    logic [DATA_WIDTH-1:0] up1_p0;
    logic [DATA_WIDTH-1:0] up2_p0;

    // Row r-1 and row r-2, both addressed by the current column.
    logic [DATA_WIDTH-1:0] lb1 [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] lb2 [IMG_WIDTH];

    logic [DATA_WIDTH-1:0] win_p1 [9];
    logic                  vld_p1;
    logic                  eof_p1;

    // ---- stage 0: position tracking and line buffer access ----
    assign clr_p0    = rst | bus.refresh;
    assign acc_p0    = bus.in_valid & ~clr_p0;
    assign in_win_p0 = (row_p0 >= ROW_W'(2)) && (col_p0 >= COL_W'(2));
    assign last_p0   = (row_p0 == ROW_LAST) && (col_p0 == COL_LAST);
    assign up1_p0    = lb1[col_p0];
    assign up2_p0    = lb2[col_p0];

    always_ff @(posedge clk) begin
        if (clr_p0) begin
            col_p0 <= '0;
            row_p0 <= '0;
        end else if (acc_p0) begin
            if (col_p0 == COL_LAST) begin
                col_p0 <= '0;
                row_p0 <= (row_p0 == ROW_LAST) ? '0 : row_p0 + 1'b1;
            end else begin
                col_p0 <= col_p0 + 1'b1;
            end
        end
    end

    // Read-before-write: the old row r-1 entry cascades down into row r-2.
    always_ff @(posedge clk) begin
        if (acc_p0) begin
            lb1[col_p0] <= bus.in_pixel;
            lb2[col_p0] <= up1_p0;
        end
    end

    // ---- stage 1: window shift register and registered flags ----
    always_ff @(posedge clk) begin
        if (clr_p0) begin
            vld_p1 <= 1'b0;
            eof_p1 <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                win_p1[i] <= '0;
            end
        end else begin
            vld_p1 <= acc_p0 & in_win_p0;
            eof_p1 <= acc_p0 & in_win_p0 & last_p0;
            if (acc_p0) begin
                for (int k = 0; k < 3; k++) begin
                    win_p1[3*k]   <= win_p1[3*k+1];
                    win_p1[3*k+1] <= win_p1[3*k+2];
                end
                win_p1[2] <= up2_p0;
                win_p1[5] <= up1_p0;
                win_p1[8] <= bus.in_pixel;
            end
        end
    end

    assign bus.out_valid = vld_p1;
    assign bus.out_eof   = eof_p1;
    assign bus.w0        = win_p1[0];
    assign bus.w1        = win_p1[1];
    assign bus.w2        = win_p1[2];
    assign bus.w3        = win_p1[3];
    assign bus.w4        = win_p1[4];
    assign bus.w5        = win_p1[5];
    assign bus.w6        = win_p1[6];
    assign bus.w7        = win_p1[7];
    assign bus.w8        = win_p1[8];
endmodule

// File: tb/tb_window_3x3_gen.sv
// Scoreboard bench for window_3x3_gen on a 4x3 frame: a frame-image model pushes
// expected windows as pixels are driven; a negedge monitor pops and compares.
module tb_window_3x3_gen;
    localparam int DW = 8;
    localparam int IW = 4;
    localparam int IH = 3;
    localparam int WW = 9 * DW + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    window_3x3_gen_if #(.DATA_WIDTH(DW)) bus ();

    window_3x3_gen #(
        .DATA_WIDTH(DW),
        .IMG_WIDTH (IW),
        .IMG_HEIGHT(IH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int nvld  = 0;
    int neof  = 0;
    bit mon_en = 1'b0;

    logic [DW-1:0] pix [IH][IW];
    int mr = 0;
    int mc = 0;
    logic [WW-1:0] exp_q [$];
    logic [WW-1:0] win_log [$];

    task automatic check(input string tag, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [WW-1:0] dut_win();
        return {bus.out_eof, bus.w0, bus.w1, bus.w2, bus.w3, bus.w4,
                bus.w5, bus.w6, bus.w7, bus.w8};
    endfunction

    // One input cycle; the frame model follows whatever the DUT should accept.
    task automatic drive(input logic v, input logic [DW-1:0] p, input logic rf, input logic rs);
        @(posedge clk);
        #1;
        bus.in_valid = v;
        bus.in_pixel = p;
        bus.refresh  = rf;
        rst          = rs;
        if (rs || rf) begin
            mr = 0;
            mc = 0;
        end else if (v) begin
            pix[mr][mc] = p;
            if (mr >= 2 && mc >= 2)
                exp_q.push_back({(mr == IH-1 && mc == IW-1),
                                 pix[mr-2][mc-2], pix[mr-2][mc-1], pix[mr-2][mc],
                                 pix[mr-1][mc-2], pix[mr-1][mc-1], pix[mr-1][mc],
                                 pix[mr][mc-2],   pix[mr][mc-1],   pix[mr][mc]});
            if (mc == IW-1) begin
                mc = 0;
                mr = (mr == IH-1) ? 0 : mr + 1;
            end else begin
                mc++;
            end
        end
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic send_frame(input bit bubbles);
        for (int r = 0; r < IH; r++)
            for (int c = 0; c < IW; c++) begin
                drive(1'b1, DW'(16*r + c), 1'b0, 1'b0);
                if (bubbles) idle();
            end
    endtask

    task automatic end_phase(input string tag, input int exp_vld, input int exp_eof);
        idle();
        idle();
        check({tag, "_nvld"}, WW'(nvld), WW'(exp_vld));
        check({tag, "_neof"}, WW'(neof), WW'(exp_eof));
        check({tag, "_qempty"}, WW'(exp_q.size()), '0);
        nvld = 0;
        neof = 0;
        exp_q.delete();
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.out_valid) begin
                nvld++;
                if (bus.out_eof) neof++;
                win_log.push_back(dut_win());
                if (exp_q.size() == 0)
                    check("unexpected_vld", WW'(bus.out_valid), '0);
                else
                    check("window", dut_win(), exp_q.pop_front());
            end else begin
                check("eof_idle", WW'(bus.out_eof), '0);
            end
        end
    end

    initial begin
        logic [WW-1:0] w_first;
        logic [WW-1:0] w_second;
        w_first  = {1'b0, 8'd0, 8'd1, 8'd2, 8'd16, 8'd17, 8'd18, 8'd32, 8'd33, 8'd34};
        w_second = {1'b1, 8'd1, 8'd2, 8'd3, 8'd17, 8'd18, 8'd19, 8'd33, 8'd34, 8'd35};
        bus.in_valid = 1'b0;
        bus.in_pixel = '0;
        bus.refresh  = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b1);
        idle();
        @(negedge clk);
        check("reset_vld", WW'(bus.out_valid), '0);
        check("reset_win", dut_win(), '0);
        mon_en = 1'b1;

        // Continuous frame
        win_log.delete();
        send_frame(1'b0);
        end_phase("cont", 2, 1);
        check("cont_win0", win_log[0], w_first);
        check("cont_win1", win_log[1], w_second);

        // Bubble after every pixel
        win_log.delete();
        send_frame(1'b1);
        end_phase("bubble", 2, 1);
        check("bubble_win0", win_log[0], w_first);
        check("bubble_win1", win_log[1], w_second);

        // Back-to-back frames
        send_frame(1'b0);
        send_frame(1'b0);
        end_phase("b2b", 4, 2);

        // Refresh after pixel (1,3) with a simultaneous pixel that must be dropped
        for (int i = 0; i < 2*IW; i++) drive(1'b1, DW'(8'hC0 + i), 1'b0, 1'b0);
        drive(1'b1, 8'd99, 1'b1, 1'b0);
        win_log.delete();
        send_frame(1'b0);
        end_phase("refresh", 2, 1);
        check("refresh_win0", win_log[0], w_first);

        // Reset mid-frame after a valid window holding non-zero data
        for (int i = 0; i < 2*IW + 3; i++) drive(1'b1, DW'(8'h50 + i), 1'b0, 1'b0);
        drive(1'b1, 8'hAA, 1'b0, 1'b1);
        idle();
        @(negedge clk);
        check("midrst_vld", WW'(bus.out_valid), '0);
        check("midrst_win", dut_win(), '0);
        end_phase("pre_rst", 1, 0);
        win_log.delete();
        send_frame(1'b0);
        end_phase("post_rst", 2, 1);
        check("post_rst_win1", win_log[1], w_second);

        // Random pixels and random bubbles over several frames
        for (int f = 0; f < 6; f++)
            for (int i = 0; i < IW*IH; i++) begin
                while ($urandom_range(0, 2) == 0) idle();
                drive(1'b1, DW'($urandom), 1'b0, 1'b0);
            end
        end_phase("random", 12, 6);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/window_3x3_gen.md
Name: window_3x3_gen

Overview:
Converts a raster-order pixel stream (one pixel per accepted cycle, left-to-right, top-to-bottom) into a 3x3 neighbourhood window for the downstream sobelfilter stage.
- Two internal line buffers hold the previous two image rows.
- A 3-column shift register forms the window.
- Windows are emitted only when all nine pixels lie inside the current frame; no border padding.

Parameters:
DATA_WIDTH, 8, bits per pixel
IMG_WIDTH, 640, pixels per row (>=3)
IMG_HEIGHT, 480, rows per frame (>=3)

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
refresh  input  1  frame start; synchronous clear of position state, same priority as rst
in_valid  input  1  in_pixel is valid this cycle
in_pixel  input  DATA_WIDTH  raster pixel
out_valid  output  1  w0..w8 hold a complete in-frame window
out_eof  output  1  with out_valid: window's newest pixel is last pixel of frame
w0..w8  output  DATA_WIDTH each  window, layout 0 1 2 / 3 4 5 / 6 7 8 (w0 top-left, w8 bottom-right = newest pixel)

Behaviour:
- Reset (rst or refresh high at a clock edge):
  - col, row counters <= 0.
  - out_valid, out_eof, w0..w8 <= 0.
  - Line buffer contents are not cleared; they are unobservable because output is gated.
  - Any in_valid pixel in that cycle is dropped.
- Position counters:
  - col advances on each accepted pixel (in_valid=1).
  - At col=IMG_WIDTH-1, col wraps to 0 and row increments.
  - At row=IMG_HEIGHT-1, col=IMG_WIDTH-1, both wrap to 0; the next pixel starts a new frame without needing refresh.
- Accepted pixel P at (r,c), all updates on the same edge:
  - Line buffers read (r-1,c) and (r-2,c) at column c and write P / (r-1,c) back in read-before-write order.
  - Window shifts left one column; new right column = {(r-2,c),(r-1,c),P} into {w2,w5,w8}.
- Validity:
  - out_valid <= 1 iff r>=2 and c>=2; otherwise 0.
  - out_eof <= out_valid condition AND r=IMG_HEIGHT-1 AND c=IMG_WIDTH-1.
- in_valid=0: window, counters and line buffers hold; out_valid <= 0, out_eof <= 0. Bubbles never corrupt the window.
- Latency: outputs reflect pixel P from the clock edge that accepts it (1 cycle, registered outputs).
- Row boundary: windows straddling rows (c<2) are produced internally but never flagged valid.
- Valid windows per frame: (IMG_HEIGHT-2)*(IMG_WIDTH-2).
- Outputs are full DATA_WIDTH, with no truncation.
- Line buffers are each IMG_WIDTH deep, DATA_WIDTH wide; addressing is by col, so no separate pointer is needed.

Test Plan:
- Use IMG_WIDTH=4, IMG_HEIGHT=3, pixel(r,c)=16r+c, in_valid continuous:
  - out_valid is high exactly two cycles.
  - First window = 0,1,2 / 16,17,18 / 32,33,34 with out_eof=0.
  - Second window = 1,2,3 / 17,18,19 / 33,34,35 with out_eof=1.
- Same stimulus with in_valid=0 inserted every other cycle -> identical window sequence; out_valid never high during bubbles.
- Two back-to-back frames without refresh -> second frame yields the same two windows. No valid window before pixel (2,2) of frame 2; stale rows from frame 1 are never flagged valid.
- Assert refresh after pixel (1,3) of a frame, then send a full frame -> first valid window is 0,1,2 / 16,17,18 / 32,33,34 of the new frame. The cycle with refresh=1 and in_valid=1 is dropped.
- Apply rst mid-frame for 1 cycle -> out_valid, out_eof, w0..w8 all 0 on the next cycle; a full frame afterwards is processed correctly.
- Default parameters (640x480), random pixels -> 478*638 = 304964 valid windows. Each window matches the reference model; exactly one out_eof pulse, on the final window.
